// File: rtl/seq_pkg.sv
// ============================================================================
// Module : seq_pkg
// Brief  : Shared state encodings, opcodes, flag indices and the immediate
//          sign-extension helper for the multicycle sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  localparam int FLAG_LOOP = 0;
  localparam int FLAG_MTO  = 1;

  // 2-bit immediate -> 8-bit two's complement, range -2..+1
  function automatic logic [7:0] sext(input logic [1:0] imm);
    return {{7{imm[1]}}, imm[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mem_timer.sv
// ============================================================================
// Module : seq_mem_timer
// Brief  : Counts data-memory wait cycles; o_expired flags the last allowed
//          wait cycle so the sequencer can fault on the same edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mem_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int c_WIDTH = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(MEM_TIMEOUT - 1);

  logic [c_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count holds the number of already-elapsed unacknowledged cycles
  assign o_expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module : multicycle_sequencer
// Brief  : Multi-cycle control FSM for the 8-bit datapath: fetch handshake,
//          DECODE/EXEC/MEM/WB strobes, PC ownership, memory-timeout and
//          self-branch halts. Optional SEQ_SINGLE_STEP_EN adds a step input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [7:0] PC_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic       inst_valid,
  input  logic [7:0] inst_data,
  output logic       inst_ready,
  output logic [7:0] ir,
  output logic [7:0] pc,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       busy,
  output logic       halted,
  output logic [1:0] flags
);

  logic [2:0] r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [1:0] r_flags;

  logic [1:0] w_op;
  logic       w_in_mem;
  logic       w_timeout;
  logic       w_phase;
  logic       w_start;
  logic [2:0] w_retire_state;
  logic [7:0] w_branch_target;

  assign w_op            = r_ir[7:6];
  assign w_in_mem        = (r_state == ST_MEM);
  assign w_branch_target = r_pc + 8'd1 + sext(r_ir[1:0]);

`ifdef SEQ_SINGLE_STEP_EN
  assign w_start        = step;
  assign w_retire_state = ST_IDLE;
`else
  assign w_start        = run;
  assign w_retire_state = run ? ST_FETCH : ST_IDLE;
`endif

  seq_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk      (clk),
    .rst      (reset),
    .i_clear  (!w_in_mem),
    .i_enable (w_in_mem && !mem_ack),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= PC_RESET;
      r_ir    <= 8'h00;
      r_flags <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (inst_valid) begin
            r_ir    <= inst_data;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_op != OP_BR) begin
            r_state <= ST_EXEC;
          end else if (r_ir[1:0] == 2'b11) begin
            // Branch to itself can never make progress
            r_flags[FLAG_LOOP] <= 1'b1;
            r_state            <= ST_HALT;
          end else begin
            r_pc    <= w_branch_target;
            r_state <= w_retire_state;
          end
        end
        ST_EXEC: begin
          r_state <= (w_op == OP_ADD) ? ST_WB : ST_MEM;
        end
        ST_MEM: begin
          // An ack on the final allowed cycle still completes the access
          if (mem_ack) begin
            if (w_op == OP_LW) begin
              r_state <= ST_WB;
            end else begin
              r_pc    <= r_pc + 8'd1;
              r_state <= w_retire_state;
            end
          end else if (w_timeout) begin
            r_flags[FLAG_MTO] <= 1'b1;
            r_state           <= ST_HALT;
          end
        end
        ST_WB: begin
          r_pc    <= r_pc + 8'd1;
          r_state <= w_retire_state;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_phase = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                   (r_state == ST_MEM)    || (r_state == ST_WB);

  assign inst_ready = (r_state == ST_FETCH);
  assign ir         = r_ir;
  assign pc         = r_pc;
  assign mem_rd     = w_in_mem && (w_op == OP_LW);
  assign mem_wr     = w_in_mem && (w_op == OP_SW);
  assign reg_we     = (r_state == ST_WB);
  assign reg_dst    = w_phase && (w_op == OP_ADD);
  assign alu_src    = w_phase && ((w_op == OP_LW) || (w_op == OP_SW));
  assign mem_to_reg = w_phase && (w_op == OP_LW);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted     = (r_state == ST_HALT);
  assign flags      = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module : tb_multicycle_sequencer
// Brief  : Self-checking bench: instruction vector table plus hand-written
//          corner sequences, writeback scoreboard checked on reg_we.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

  localparam logic [1:0] T_ADD = 2'b00;
  localparam logic [1:0] T_LW  = 2'b01;
  localparam logic [1:0] T_SW  = 2'b10;

  logic       clk = 1'b0;
  logic       reset, run, inst_valid, mem_ack;
  logic [7:0] inst_data;
  logic       inst_ready, mem_rd, mem_wr, reg_we, alu_src, reg_dst, mem_to_reg;
  logic       busy, halted;
  logic [7:0] ir, pc;
  logic [1:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [7:0] inst;
    int         ack_after;
    int         exp_we;
    int         exp_mem;
    logic [7:0] exp_pc;
    logic       exp_halt;
    logic [1:0] exp_flags;
  } vec_t;

  typedef struct packed {
    logic [7:0] ir;
    logic       dst;
    logic       src;
    logic       m2r;
  } wb_t;

  vec_t vecs[13];
  wb_t  sb[$];

  multicycle_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .inst_valid(inst_valid),
    .inst_data (inst_data),
    .inst_ready(inst_ready),
    .ir        (ir),
    .pc        (pc),
    .mem_ack   (mem_ack),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .reg_we    (reg_we),
    .alu_src   (alu_src),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .busy      (busy),
    .halted    (halted),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {reg_dst, alu_src, mem_to_reg} by opcode
  function automatic logic [2:0] exp_ctl(input logic [1:0] op);
    case (op)
      T_ADD:   return 3'b100;
      T_LW:    return 3'b011;
      T_SW:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    inst_valid = 1'b0;
    mem_ack    = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic handshake(input logic [7:0] inst, input string tag);
    logic [1:0] op;
    op = inst[7:6];
    for (int w = 0; w < 20; w++) begin
      if (inst_ready) break;
      tick();
    end
    chk({tag, "_fetch_ready"}, int'(inst_ready), 1);
    inst_valid = 1'b1;
    inst_data  = inst;
    if (op == T_ADD || op == T_LW)
      sb.push_back('{inst, op == T_ADD, op == T_LW, op == T_LW});
    tick();
    inst_valid = 1'b0;
    inst_data  = 8'h00;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    we_off, we_cnt, m;
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.rst) do_reset();
    handshake(v.inst, tag);
    chk({tag, "_ir"}, int'(ir), int'(v.inst));
    chk({tag, "_ctl"}, int'({reg_dst, alu_src, mem_to_reg}), int'(exp_ctl(v.inst[7:6])));
    we_off = -1;
    we_cnt = 0;
    m      = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_rd || mem_wr) begin
        m++;
        mem_ack = (m == v.ack_after);
      end else begin
        mem_ack = 1'b0;
      end
      if (reg_we) begin
        if (we_off < 0) we_off = k;
        we_cnt++;
      end
      if (inst_ready || halted || !busy) break;
      tick();
    end
    mem_ack = 1'b0;
    chk({tag, "_we_cycle"}, we_off, v.exp_we);
    chk({tag, "_we_count"}, we_cnt, (v.exp_we >= 0) ? 1 : 0);
    chk({tag, "_mem_cycles"}, m, v.exp_mem);
    chk({tag, "_pc"}, int'(pc), int'(v.exp_pc));
    chk({tag, "_halted"}, int'(halted), int'(v.exp_halt));
    chk({tag, "_flags"}, int'(flags), int'(v.exp_flags));
  endtask

  // Writeback scoreboard and strobe exclusivity
  always @(negedge clk) begin
    if (!reset && reg_we) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_we: got ir=%h expected no writeback", ir);
      end else begin
        wb_t e, a;
        e = sb.pop_front();
        a = '{ir, reg_dst, alu_src, mem_to_reg};
        if (a != e) begin
          n_fail++;
          $display("FAIL sb_writeback: got %h expected %h", a, e);
        end
      end
    end
    if (mem_rd && mem_wr) begin
      n_tests++;
      n_fail++;
      $display("FAIL mem_excl: got rd=1 wr=1 expected at most one");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; run = 1'b0; inst_valid = 1'b0; inst_data = 8'h00; mem_ack = 1'b0;

    //            rst   inst   ack we  mem pc     halt  flags
    vecs[0]  = '{1'b1, 8'h1B, 0,  3,  0,  8'h01, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 8'h45, 3,  6,  3,  8'h02, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 8'h84, 1,  -1, 1,  8'h03, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 8'h00, 0,  3,  0,  8'h04, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 8'h2E, 0,  3,  0,  8'h05, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 8'hC1, 0,  -1, 0,  8'h07, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 8'hC2, 0,  -1, 0,  8'h06, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 8'h1B, 0,  3,  0,  8'h07, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 8'hC3, 0,  -1, 0,  8'h07, 1'b1, 2'b01};
    vecs[9]  = '{1'b1, 8'hC2, 0,  -1, 0,  8'hFF, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 8'h1F, 0,  3,  0,  8'h00, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 8'h45, 1,  4,  1,  8'h01, 1'b0, 2'b00};
    vecs[12] = '{1'b1, 8'h88, 0,  -1, 15, 8'h00, 1'b1, 2'b10};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", int'(pc), 0);
    chk("rst_ir", int'(ir), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_ctl", int'({busy, halted, inst_ready, mem_rd, mem_wr, reg_we,
                         reg_dst, alu_src, mem_to_reg}), 0);
    tick();
    chk("idle_hold_run0", int'(inst_ready), 0);
    run = 1'b1;
    tick();
    chk("idle_to_fetch", int'(inst_ready), 1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // HALT ignores run and instruction offers
    run = 1'b1; inst_valid = 1'b1; inst_data = 8'h1B;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (inst_ready || !halted || mem_wr || busy) bad++;
    end
    inst_valid = 1'b0;
    chk("halt_hold", bad, 0);
    chk("halt_pc", int'(pc), 0);

    // Reset during MEM abandons the load
    do_reset();
    handshake(8'h45, "rstmem");
    tick();
    tick();
    chk("rstmem_rd_high", int'(mem_rd), 1);
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    chk("rstmem_ctl", int'({mem_rd, reg_we, busy, inst_ready}), 0);
    chk("rstmem_pc", int'(pc), 0);
    chk("rstmem_flags", int'(flags), 0);

    // run drops mid-instruction: ADD still completes, then IDLE
    handshake(8'h1B, "run0");
    run = 1'b0;
    tick();
    tick();
    chk("run0_we", int'(reg_we), 1);
    tick();
    chk("run0_idle", int'({inst_ready, busy}), 0);
    chk("run0_pc", int'(pc), 1);
    tick();
    chk("run0_idle_hold", int'(inst_ready), 0);
    run = 1'b1;
    tick();
    chk("run1_fetch", int'(inst_ready), 1);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
